// File: rtl/grid_pixel_sampler_pkg.sv
// Shared types and elaboration-time helpers for the grid pixel sampler.
package grid_pixel_sampler_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READOUT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int unsigned pixel_width(int unsigned bytes_per_pixel);
    return BYTE_W * bytes_per_pixel;
  endfunction

  // Centre of cell idx when count positions are split into span equal cells.
  function automatic int unsigned sample_pos(int unsigned idx, int unsigned count,
                                             int unsigned span);
    return ((2 * idx + 1) * count) / (2 * span);
  endfunction

endpackage

// File: rtl/grid_pixel_sampler_if.sv
// Sample readout port: valid/ready stream of stored grid pixels.
interface grid_pixel_sampler_if #(
  parameter int unsigned PIXEL_W = 16
) ();

  logic               rd_valid;
  logic               rd_ready;
  logic [PIXEL_W-1:0] rd_data;
  logic [1:0]         rd_row;
  logic [1:0]         rd_col;
  logic               rd_last;

  modport master (
    output rd_valid, rd_data, rd_row, rd_col, rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_data, rd_row, rd_col, rd_last,
    output rd_ready
  );

endinterface

// File: rtl/grid_pixel_sampler_pos_matcher.sv
// Flags when a counter sits on one of SPAN cell centres and reports which one.
module grid_pixel_sampler_pos_matcher
  import grid_pixel_sampler_pkg::*;
#(
  parameter int unsigned COUNT = 120,
  parameter int unsigned SPAN  = 3,
  parameter int unsigned CW    = 7
) (
  input  logic [CW-1:0] value_i,
  output logic          hit_o,
  output logic [1:0]    index_o
);

  always_comb begin
    hit_o   = 1'b0;
    index_o = 2'd0;
    for (int unsigned i = 0; i < SPAN; i++) begin
      if (value_i == CW'(sample_pos(i, COUNT, SPAN))) begin
        hit_o   = 1'b1;
        index_o = 2'(i);
      end
    end
  end

endmodule

// File: rtl/grid_pixel_sampler.sv
// Captures one camera frame from a byte stream, keeps the grid-centre pixels
// and streams them out row-major once the frame is complete.
module grid_pixel_sampler
  import grid_pixel_sampler_pkg::*;
#(
  parameter int unsigned LINES           = 120,
  parameter int unsigned COLUMNS         = 320,
  parameter int unsigned GRID_ROWS       = 3,
  parameter int unsigned GRID_COLS       = 3,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned S_LINE          = 7,
  parameter int unsigned S_COLUMN        = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  grid_pixel_sampler_if.master rd,
  output logic                busy,
  output logic                done,
  output logic [S_LINE-1:0]   db_line,
  output logic [S_COLUMN-1:0] db_column
);

  localparam int unsigned PIXEL_W    = pixel_width(BYTES_PER_PIXEL);
  localparam int unsigned N_SAMPLES  = GRID_ROWS * GRID_COLS;
  localparam int unsigned IDX_W      = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic        LAST_PHASE = 1'(BYTES_PER_PIXEL - 1);

  state_e               state_q, state_d;
  logic [S_LINE-1:0]    line_q, line_d;
  logic [S_COLUMN-1:0]  col_q, col_d;
  logic                 phase_q, phase_d;
  logic [PIXEL_W-1:0]   pix_q, pix_d;
  logic [PIXEL_W-1:0]   assembled;
  logic [1:0]           rrow_q, rrow_d, rcol_q, rcol_d;
  logic [PIXEL_W-1:0]   rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 store_we;
  logic [IDX_W-1:0]     widx, ridx;
  logic [PIXEL_W-1:0]   store_q [N_SAMPLES];
  logic                 line_hit, col_hit;
  logic [1:0]           line_idx, col_idx;

  grid_pixel_sampler_pos_matcher #(.COUNT(LINES), .SPAN(GRID_ROWS), .CW(S_LINE)) u_line_match (
    .value_i (line_q),
    .hit_o   (line_hit),
    .index_o (line_idx)
  );

  grid_pixel_sampler_pos_matcher #(.COUNT(COLUMNS), .SPAN(GRID_COLS), .CW(S_COLUMN)) u_col_match (
    .value_i (col_q),
    .hit_o   (col_hit),
    .index_o (col_idx)
  );

  assign widx = IDX_W'(32'(line_idx) * GRID_COLS + 32'(col_idx));

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    col_d     = col_q;
    phase_d   = phase_q;
    pix_d     = pix_q;
    rrow_d    = rrow_q;
    rcol_d    = rcol_q;
    store_we  = 1'b0;
    // Earlier bytes shift toward the MSBs, so the first byte ends up on top.
    assembled = PIXEL_W'({pix_q, byte_data});

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CAPTURE;
            line_d  = '0;
            col_d   = '0;
            phase_d = 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (byte_valid) begin
            pix_d = assembled;
            if (phase_q == LAST_PHASE) begin
              phase_d  = 1'b0;
              store_we = line_hit & col_hit;
              if (col_q == S_COLUMN'(COLUMNS - 1)) begin
                col_d = '0;
                if (line_q == S_LINE'(LINES - 1)) begin
                  line_d  = '0;
                  state_d = ST_READOUT;
                end else begin
                  line_d = line_q + S_LINE'(1);
                end
              end else begin
                col_d = col_q + S_COLUMN'(1);
              end
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        ST_READOUT: begin
          if (rvalid_q && rd.rd_ready) begin
            if (rcol_q == 2'(GRID_COLS - 1)) begin
              rcol_d = 2'd0;
              if (rrow_q == 2'(GRID_ROWS - 1)) begin
                state_d = ST_DONE;
              end else begin
                rrow_d = rrow_q + 2'd1;
              end
            end else begin
              rcol_d = rcol_q + 2'd1;
            end
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Readout index restarts at 0 whenever the next state is not READOUT.
    if (state_d != ST_READOUT) begin
      rrow_d = 2'd0;
      rcol_d = 2'd0;
    end

    ridx     = IDX_W'(32'(rrow_d) * GRID_COLS + 32'(rcol_d));
    rvalid_d = (state_d == ST_READOUT);
    rdata_d  = rvalid_d ? store_q[ridx] : '0;
    rlast_d  = rvalid_d && (rrow_d == 2'(GRID_ROWS - 1)) && (rcol_d == 2'(GRID_COLS - 1));
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      col_q    <= '0;
      phase_q  <= 1'b0;
      pix_q    <= '0;
      rrow_q   <= 2'd0;
      rcol_q   <= 2'd0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      col_q    <= col_d;
      phase_q  <= phase_d;
      pix_q    <= pix_d;
      rrow_q   <= rrow_d;
      rcol_q   <= rcol_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Sample store survives start and abort; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_SAMPLES; i++) begin
        store_q[i] <= '0;
      end
    end else if (store_we) begin
      store_q[widx] <= assembled;
    end
  end

  assign rd.rd_valid = rvalid_q;
  assign rd.rd_data  = rdata_q;
  assign rd.rd_row   = rrow_q;
  assign rd.rd_col   = rcol_q;
  assign rd.rd_last  = rlast_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign db_line     = line_q;
  assign db_column   = col_q;

endmodule

// File: tb/tb_grid_pixel_sampler.sv
// Bench for grid_pixel_sampler: two instances (2-byte 3x3 grid, 1-byte 2x2 grid)
// checked against a per-pixel reference store of expected grid samples.
module tb_grid_pixel_sampler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       st [2];
  logic       ab [2];
  logic       bv [2];
  logic       rr [2];
  logic [7:0] bd [2];

  logic        vld [2];
  logic        lst [2];
  logic        bsy [2];
  logic        dne [2];
  logic [15:0] dat [2];
  logic [1:0]  row [2];
  logic [1:0]  col [2];
  logic [7:0]  dbl [2];
  logic [7:0]  dbc [2];

  logic       busy_a, done_a, busy_b, done_b;
  logic [4:0] dbl_a;
  logic [5:0] dbc_a;
  logic [2:0] dbl_b, dbc_b;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] exp_store [2][16];

  grid_pixel_sampler_if #(.PIXEL_W(16)) rd_a ();
  grid_pixel_sampler_if #(.PIXEL_W(8))  rd_b ();

  grid_pixel_sampler #(
    .LINES(30), .COLUMNS(40), .GRID_ROWS(3), .GRID_COLS(3),
    .BYTES_PER_PIXEL(2), .S_LINE(5), .S_COLUMN(6)
  ) dut_a (
    .clock(clock), .reset(reset), .start(st[0]), .abort(ab[0]),
    .byte_valid(bv[0]), .byte_data(bd[0]), .rd(rd_a.master),
    .busy(busy_a), .done(done_a), .db_line(dbl_a), .db_column(dbc_a)
  );

  grid_pixel_sampler #(
    .LINES(8), .COLUMNS(8), .GRID_ROWS(2), .GRID_COLS(2),
    .BYTES_PER_PIXEL(1), .S_LINE(3), .S_COLUMN(3)
  ) dut_b (
    .clock(clock), .reset(reset), .start(st[1]), .abort(ab[1]),
    .byte_valid(bv[1]), .byte_data(bd[1]), .rd(rd_b.master),
    .busy(busy_b), .done(done_b), .db_line(dbl_b), .db_column(dbc_b)
  );

  assign rd_a.rd_ready = rr[0];
  assign rd_b.rd_ready = rr[1];

  assign vld[0] = rd_a.rd_valid;  assign vld[1] = rd_b.rd_valid;
  assign lst[0] = rd_a.rd_last;   assign lst[1] = rd_b.rd_last;
  assign dat[0] = rd_a.rd_data;   assign dat[1] = {8'h00, rd_b.rd_data};
  assign row[0] = rd_a.rd_row;    assign row[1] = rd_b.rd_row;
  assign col[0] = rd_a.rd_col;    assign col[1] = rd_b.rd_col;
  assign bsy[0] = busy_a;         assign bsy[1] = busy_b;
  assign dne[0] = done_a;         assign dne[1] = done_b;
  assign dbl[0] = 8'(dbl_a);      assign dbl[1] = 8'(dbl_b);
  assign dbc[0] = 8'(dbc_a);      assign dbc[1] = 8'(dbc_b);

  function automatic int ln(int w);  return (w == 0) ? 30 : 8; endfunction
  function automatic int cn(int w);  return (w == 0) ? 40 : 8; endfunction
  function automatic int gr(int w);  return (w == 0) ? 3 : 2;  endfunction
  function automatic int gc(int w);  return (w == 0) ? 3 : 2;  endfunction
  function automatic int bpp(int w); return (w == 0) ? 2 : 1;  endfunction

  // Row-major sample slot of pixel (line, col), or -1 if it is not a grid centre.
  function automatic int sidx(int w, int line, int c);
    int r = -1;
    int k = -1;
    for (int i = 0; i < gr(w); i++)
      if (line == (2 * i + 1) * ln(w) / (2 * gr(w))) r = i;
    for (int j = 0; j < gc(w); j++)
      if (c == (2 * j + 1) * cn(w) / (2 * gc(w))) k = j;
    return (r < 0 || k < 0) ? -1 : r * gc(w) + k;
  endfunction

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++) exp_store[w][i] = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(int w, logic [15:0] val, int line, int c, bit noisy);
    int si;
    for (int b = 0; b < bpp(w); b++) begin
      if ($urandom_range(0, 3) == 0) begin
        bv[w] = 1'b0;
        if (noisy) st[w] = 1'b1;
        tick();
        st[w] = 1'b0;
      end
      bv[w] = 1'b1;
      bd[w] = (bpp(w) == 2 && b == 0) ? val[15:8] : val[7:0];
      tick();
      bv[w] = 1'b0;
    end
    si = sidx(w, line, c);
    if (si >= 0) exp_store[w][si] = (bpp(w) == 2) ? val : {8'h00, val[7:0]};
  endtask

  // mode 0: {line,col} pattern, 1: random pixels, 2: random pixels plus stray start pulses.
  task automatic capture(int w, int mode, int stop_after);
    st[w] = 1'b1;
    tick();
    st[w] = 1'b0;
    vectors++;
    if (bsy[w] !== 1'b1 || dbl[w] !== 8'd0 || dbc[w] !== 8'd0) begin
      errors++;
      $display("FAIL capture_entry dut%0d: busy=%b line=%0d col=%0d, required busy=1 line=0 col=0",
               w, bsy[w], dbl[w], dbc[w]);
    end
    for (int p = 0; p < ln(w) * cn(w); p++) begin
      int line = p / cn(w);
      int c    = p % cn(w);
      logic [15:0] val;
      if (p == stop_after) return;
      val = (mode == 0) ? {8'(line), 8'(c)} : 16'($urandom);
      send_pixel(w, val, line, c, mode == 2);
    end
  endtask

  // mode 0: always ready, 1: random ready with stray bytes, 2: 5-cycle stall at k=4.
  task automatic readout(int w, int mode, int reset_k);
    int n     = gr(w) * gc(w);
    int k     = 0;
    int stall = 0;
    int cyc   = 0;
    while (k < n && cyc < 400) begin
      vectors++;
      if (vld[w] !== 1'b1 || dat[w] !== exp_store[w][k] || row[w] !== 2'(k / gc(w)) ||
          col[w] !== 2'(k % gc(w)) || lst[w] !== (k == n - 1)) begin
        errors++;
        $display("FAIL readout dut%0d k=%0d: valid=%b data=%h row=%0d col=%0d last=%b, required valid=1 data=%h row=%0d col=%0d last=%b",
                 w, k, vld[w], dat[w], row[w], col[w], lst[w], exp_store[w][k], k / gc(w),
                 k % gc(w), k == n - 1);
      end
      if (k == reset_k) begin
        rr[w] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (vld[w] !== 1'b0 || bsy[w] !== 1'b0 || dat[w] !== 16'h0000 || dbl[w] !== 8'd0) begin
          errors++;
          $display("FAIL reset_in_readout dut%0d: valid=%b busy=%b data=%h line=%0d, required 0 0 0000 0",
                   w, vld[w], bsy[w], dat[w], dbl[w]);
        end
        clear_model();
        return;
      end
      case (mode)
        1: begin
          rr[w] = 1'($urandom_range(0, 1));
          bv[w] = 1'($urandom_range(0, 1));
          bd[w] = 8'($urandom);
        end
        2: begin
          rr[w] = !(k == 4 && stall < 5);
          if (k == 4 && stall < 5) stall++;
        end
        default: rr[w] = 1'b1;
      endcase
      tick();
      if (rr[w]) k++;
      cyc++;
    end
    rr[w] = 1'b0;
    bv[w] = 1'b0;
    if (k < n) begin
      errors++;
      $display("FAIL readout_timeout dut%0d: transfers=%0d, required %0d", w, k, n);
    end
    vectors++;
    if (dne[w] !== 1'b1 || vld[w] !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse dut%0d: done=%b valid=%b, required done=1 valid=0", w, dne[w], vld[w]);
    end
    tick();
    vectors++;
    if (dne[w] !== 1'b0 || bsy[w] !== 1'b0) begin
      errors++;
      $display("FAIL done_clear dut%0d: done=%b busy=%b, required done=0 busy=0", w, dne[w], bsy[w]);
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      st[w] = 1'b0; ab[w] = 1'b0; bv[w] = 1'b0; rr[w] = 1'b0; bd[w] = 8'h00;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
    for (int w = 0; w < 2; w++) begin
      vectors++;
      if (vld[w] !== 1'b0 || lst[w] !== 1'b0 || bsy[w] !== 1'b0 || dne[w] !== 1'b0 ||
          dat[w] !== 16'h0000 || row[w] !== 2'd0 || col[w] !== 2'd0 ||
          dbl[w] !== 8'd0 || dbc[w] !== 8'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid=%b last=%b busy=%b done=%b data=%h row=%0d col=%0d line=%0d column=%0d, required all 0",
                 w, vld[w], lst[w], bsy[w], dne[w], dat[w], row[w], col[w], dbl[w], dbc[w]);
      end
    end
  endtask

  task automatic test_idle_bytes();
    for (int i = 0; i < 6; i++) begin
      bv[0] = 1'b1;
      bd[0] = 8'($urandom);
      tick();
    end
    bv[0] = 1'b0;
    vectors++;
    if (dbl[0] !== 8'd0 || dbc[0] !== 8'd0 || bsy[0] !== 1'b0 || vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_bytes: line=%0d col=%0d busy=%b valid=%b, required 0 0 0 0",
               dbl[0], dbc[0], bsy[0], vld[0]);
    end
  endtask

  task automatic test_pattern_frame();
    capture(0, 0, -1);
    readout(0, 0, -1);
  endtask

  task automatic test_stall();
    capture(0, 1, -1);
    readout(0, 2, -1);
  endtask

  task automatic test_small_grid();
    capture(1, 1, -1);
    readout(1, 1, -1);
  endtask

  task automatic test_abort();
    capture(0, 1, 1000);
    bv[0] = 1'b1;
    bd[0] = 8'($urandom);
    tick();
    bv[0] = 1'b0;
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    vectors++;
    if (bsy[0] !== 1'b0 || vld[0] !== 1'b0 || dbl[0] !== 8'(1000 / cn(0)) ||
        dbc[0] !== 8'(1000 % cn(0))) begin
      errors++;
      $display("FAIL abort: busy=%b valid=%b line=%0d col=%0d, required busy=0 valid=0 line=%0d col=%0d",
               bsy[0], vld[0], dbl[0], dbc[0], 1000 / cn(0), 1000 % cn(0));
    end
    ab[0] = 1'b1;
    st[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    st[0] = 1'b0;
    tick();
    vectors++;
    if (bsy[0] !== 1'b0 || vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: busy=%b valid=%b, required busy=0 valid=0", bsy[0], vld[0]);
    end
    capture(0, 1, -1);
    readout(0, 0, -1);
  endtask

  task automatic test_ignored_events();
    capture(0, 2, -1);
    readout(0, 1, -1);
    capture(1, 2, -1);
    readout(1, 1, -1);
  endtask

  task automatic test_reset_in_readout();
    capture(0, 1, -1);
    readout(0, 0, 4);
    capture(0, 1, -1);
    readout(0, 1, -1);
  endtask

  task automatic test_back_to_back();
    capture(1, 1, -1);
    readout(1, 0, -1);
    capture(1, 1, -1);
    readout(1, 2, -1);
  endtask

  initial begin
    test_reset();
    test_idle_bytes();
    test_pattern_frame();
    test_stall();
    test_small_grid();
    test_abort();
    test_ignored_events();
    test_reset_in_readout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required test sequence to finish");
    $fatal(1, "watchdog");
  end

endmodule
